// File: rtl/vga_timing_generator_param.sv
// Parametrised display timing generator: position counters, sync/active
// decode, line/frame start levels and a completed-frame counter.
// The position advances only on clock edges qualified by pix_en, and every
// output is decoded from the next position so it is registered in lock-step
// with x/y.
module vga_timing_generator_param #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CW       = 10,
   parameter int FCW      = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pix_en,
   output logic           hs,
   output logic           vs,
   output logic           active_video_area,
   output logic [CW-1:0]  x,
   output logic [CW-1:0]  y,
   output logic           line_start,
   output logic           frame_start,
   output logic [FCW-1:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Zero-width regions or counters too narrow for the totals cannot work.
   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
       CW < 1 || CW > 30 || FCW < 1 ||
       H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cfg
      $error("vga_timing_generator_param: invalid timing configuration");
   end

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_L  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_L  = CW'(V_ACTIVE);
   // Sync windows are [start, end); end never exceeds the last position
   // because the back porch is at least one unit wide.
   localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          HS_ON    = (HS_POL != 0);
   localparam logic          VS_ON    = (VS_POL != 0);

   logic [CW-1:0] x_nxt;
   logic [CW-1:0] y_nxt;
   logic          x_wrap;
   logic          at_origin;
   logic          first_frame;

   // Next position: x wraps at the end of a line, y steps only on that wrap.
   always_comb begin
      x_wrap = (x == H_LAST);
      x_nxt  = x_wrap ? '0 : x + CW'(1);
      y_nxt  = y;
      if (x_wrap) begin
         y_nxt = (y == V_LAST) ? '0 : y + CW'(1);
      end
      at_origin = (x_nxt == '0) && (y_nxt == '0);
   end

   // Position, decoded outputs and frame bookkeeping advance together.
   always_ff @(posedge clk) begin
      if (rst) begin
         x                 <= H_LAST;
         y                 <= V_LAST;
         hs                <= ~HS_ON;
         vs                <= ~VS_ON;
         active_video_area <= 1'b0;
         line_start        <= 1'b0;
         frame_start       <= 1'b0;
         frame_cnt         <= '0;
         first_frame       <= 1'b1;
      end else if (pix_en) begin
         x                 <= x_nxt;
         y                 <= y_nxt;
         hs                <= ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? HS_ON : ~HS_ON;
         vs                <= ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? VS_ON : ~VS_ON;
         active_video_area <= (x_nxt < H_ACT_L) && (y_nxt < V_ACT_L);
         line_start        <= (x_nxt == '0);
         frame_start       <= at_origin;
         // The first arrival at the origin after reset opens frame 0 and is
         // not a completed frame.
         if (at_origin) begin
            if (first_frame) begin
               first_frame <= 1'b0;
            end else begin
               frame_cnt <= frame_cnt + FCW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_generator_param.sv
// Bench for vga_timing_generator_param: three configurations (defaults,
// a tiny active-high one with a 2-bit frame counter, a tiny active-low one)
// checked against an arithmetic model of position versus enabled-edge count.
module tb_vga_timing_generator_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;

   // ---------------- DUT 0: defaults ----------------
   logic rst0, pen0;
   logic d0_hs, d0_vs, d0_act, d0_ls, d0_fs;
   logic [9:0] d0_x, d0_y;
   logic [7:0] d0_fc;
   vga_timing_generator_param dut0 (
      .clk(clk), .rst(rst0), .pix_en(pen0), .hs(d0_hs), .vs(d0_vs),
      .active_video_area(d0_act), .x(d0_x), .y(d0_y), .line_start(d0_ls),
      .frame_start(d0_fs), .frame_cnt(d0_fc));

   // ---------------- DUT 1: 15 x 7, active-high syncs, FCW=2 ----------------
   logic rst1, pen1;
   logic d1_hs, d1_vs, d1_act, d1_ls, d1_fs;
   logic [3:0] d1_x, d1_y;
   logic [1:0] d1_fc;
   vga_timing_generator_param #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .CW(4), .FCW(2)) dut1 (
      .clk(clk), .rst(rst1), .pix_en(pen1), .hs(d1_hs), .vs(d1_vs),
      .active_video_area(d1_act), .x(d1_x), .y(d1_y), .line_start(d1_ls),
      .frame_start(d1_fs), .frame_cnt(d1_fc));

   // ---------------- DUT 2: 8 x 8, active-low syncs, FCW=3 ----------------
   logic rst2, pen2;
   logic d2_hs, d2_vs, d2_act, d2_ls, d2_fs;
   logic [3:0] d2_x, d2_y;
   logic [2:0] d2_fc;
   vga_timing_generator_param #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(2), .V_SYNC(2), .V_BP(1),
      .HS_POL(0), .VS_POL(0), .CW(4), .FCW(3)) dut2 (
      .clk(clk), .rst(rst2), .pix_en(pen2), .hs(d2_hs), .vs(d2_vs),
      .active_video_area(d2_act), .x(d2_x), .y(d2_y), .line_start(d2_ls),
      .frame_start(d2_fs), .frame_cnt(d2_fc));

   // Packed views: {hs, vs, active, line_start, frame_start, x, y, frame_cnt}
   logic [52:0] obs0, obs1, obs2;
   assign obs0 = {d0_hs, d0_vs, d0_act, d0_ls, d0_fs, 16'(d0_x), 16'(d0_y), 16'(d0_fc)};
   assign obs1 = {d1_hs, d1_vs, d1_act, d1_ls, d1_fs, 16'(d1_x), 16'(d1_y), 16'(d1_fc)};
   assign obs2 = {d2_hs, d2_vs, d2_act, d2_ls, d2_fs, 16'(d2_x), 16'(d2_y), 16'(d2_fc)};

   // Enabled edges since the last reset edge, per DUT.
   longint n0 = 0, n1 = 0, n2 = 0;

   // Reference: after n enabled edges the raster index is n-1, so position
   // and completed frames follow from plain division; n=0 is the reset state.
   function automatic logic [52:0] model(input longint n,
         input int ha, input int hf, input int hw, input int hb,
         input int va, input int vf, input int vw, input int vb,
         input int hp, input int vp, input int fcw);
      int ht, vt, xi, yi;
      longint p, fc;
      logic hsv, vsv, act, ls, fs;
      ht = ha + hf + hw + hb;
      vt = va + vf + vw + vb;
      if (n == 0) begin
         xi = ht - 1; yi = vt - 1; fc = 0;
         hsv = (hp == 0); vsv = (vp == 0);
         act = 1'b0; ls = 1'b0; fs = 1'b0;
      end else begin
         p  = (n - 1) % (ht * vt);
         xi = int'(p % ht);
         yi = int'(p / ht);
         fc = ((n - 1) / (ht * vt)) % (longint'(1) << fcw);
         hsv = ((xi >= ha + hf) && (xi < ha + hf + hw)) ? (hp != 0) : (hp == 0);
         vsv = ((yi >= va + vf) && (yi < va + vf + vw)) ? (vp != 0) : (vp == 0);
         act = (xi < ha) && (yi < va);
         ls  = (xi == 0);
         fs  = (xi == 0) && (yi == 0);
      end
      return {hsv, vsv, act, ls, fs, 16'(xi), 16'(yi), 16'(fc)};
   endfunction

   function automatic logic [52:0] exp0(input longint n);
      return model(n, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 8);
   endfunction
   function automatic logic [52:0] exp1(input longint n);
      return model(n, 8, 2, 3, 2, 4, 1, 1, 1, 1, 1, 2);
   endfunction
   function automatic logic [52:0] exp2(input longint n);
      return model(n, 4, 1, 2, 1, 3, 2, 2, 1, 0, 0, 3);
   endfunction

   // One clock per call; outputs are sampled 1 time unit after the edge.
   task automatic tick0(input logic r, input logic en);
      rst0 = r; pen0 = en;
      @(posedge clk); #1;
      if (r) n0 = 0; else if (en) n0++;
   endtask
   task automatic tick1(input logic r, input logic en);
      rst1 = r; pen1 = en;
      @(posedge clk); #1;
      if (r) n1 = 0; else if (en) n1++;
   endtask
   task automatic tick2(input logic r, input logic en);
      rst2 = r; pen2 = en;
      @(posedge clk); #1;
      if (r) n2 = 0; else if (en) n2++;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         tick0(1'b1, logic'(i & 1)); tick1(1'b1, logic'(i & 1)); tick2(1'b1, 1'b1);
         n_run++;
         if (obs0 !== exp0(n0)) begin n_fail++; $display("FAIL reset0 got=%h exp=%h", obs0, exp0(n0)); end
         n_run++;
         if (obs1 !== exp1(n1)) begin n_fail++; $display("FAIL reset1 got=%h exp=%h", obs1, exp1(n1)); end
         n_run++;
         if (obs2 !== exp2(n2)) begin n_fail++; $display("FAIL reset2 got=%h exp=%h", obs2, exp2(n2)); end
      end
      n_run++;
      if ({d0_x, d0_y, d0_hs, d0_vs, d0_act, d0_fc} !== {10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 8'd0}) begin
         n_fail++;
         $display("FAIL reset0_const x=%0d y=%0d hs=%b vs=%b act=%b fc=%0d exp 799/524/1/1/0/0",
                  d0_x, d0_y, d0_hs, d0_vs, d0_act, d0_fc);
      end
   endtask

   task automatic test_line;
      int hs_low, ls_cnt;
      hs_low = 0; ls_cnt = 0;
      for (int i = 0; i < 1600; i++) begin
         tick0(1'b0, 1'b1);
         n_run++;
         if (obs0 !== exp0(n0)) begin n_fail++; $display("FAIL line i=%0d got=%h exp=%h", i, obs0, exp0(n0)); end
         if (i == 0) begin
            n_run++;
            if ({d0_x, d0_y, d0_act, d0_ls, d0_fs, d0_hs, d0_vs} !== {10'd0, 10'd0, 5'b11111}) begin
               n_fail++;
               $display("FAIL first_edge x=%0d y=%0d act=%b ls=%b fs=%b hs=%b vs=%b exp 0/0/1/1/1/1/1",
                        d0_x, d0_y, d0_act, d0_ls, d0_fs, d0_hs, d0_vs);
            end
         end
         if (!d0_hs) hs_low++;
         if (d0_ls) ls_cnt++;
      end
      n_run++;
      if (hs_low !== 192) begin n_fail++; $display("FAIL hs_low_edges got=%0d exp=192", hs_low); end
      n_run++;
      if (ls_cnt !== 2) begin n_fail++; $display("FAIL line_starts got=%0d exp=2", ls_cnt); end
   endtask

   task automatic test_pix_en;
      logic [52:0] prev;
      logic en;
      tick0(1'b1, 1'b0); tick0(1'b1, 1'b0);
      prev = obs0;
      for (int i = 0; i < 1200; i++) begin
         en = (i < 400) ? ~logic'(i & 1) : logic'($urandom_range(0, 1));
         tick0(1'b0, en);
         n_run++;
         if (obs0 !== exp0(n0)) begin n_fail++; $display("FAIL pix_en i=%0d got=%h exp=%h", i, obs0, exp0(n0)); end
         if (!en) begin
            n_run++;
            if (obs0 !== prev) begin n_fail++; $display("FAIL hold i=%0d got=%h exp=%h", i, obs0, prev); end
         end
         prev = obs0;
      end
   endtask

   task automatic test_reset_mid;
      tick0(1'b1, 1'b1);
      for (int i = 0; i < 301; i++) tick0(1'b0, 1'b1);
      tick0(1'b0, 1'b0);
      tick0(1'b1, 1'b0);
      n_run++;
      if ({d0_x, d0_y, d0_hs, d0_vs, d0_act, d0_fs, d0_fc} !== {10'd799, 10'd524, 4'b1100, 8'd0}) begin
         n_fail++;
         $display("FAIL mid_reset0 x=%0d y=%0d hs=%b vs=%b act=%b fs=%b fc=%0d exp 799/524/1/1/0/0/0",
                  d0_x, d0_y, d0_hs, d0_vs, d0_act, d0_fs, d0_fc);
      end
      tick0(1'b0, 1'b0);
      n_run++;
      if (obs0 !== exp0(0)) begin n_fail++; $display("FAIL mid_hold0 got=%h exp=%h", obs0, exp0(0)); end
      tick0(1'b0, 1'b1);
      n_run++;
      if ({d0_x, d0_y, d0_fs, d0_fc} !== {10'd0, 10'd0, 1'b1, 8'd0}) begin
         n_fail++;
         $display("FAIL mid_restart0 x=%0d y=%0d fs=%b fc=%0d exp 0/0/1/0", d0_x, d0_y, d0_fs, d0_fc);
      end
      // Same scenario on the small config after a frame has been counted.
      tick1(1'b1, 1'b0);
      for (int i = 0; i < 160; i++) tick1(1'b0, 1'b1);
      n_run++;
      if (d1_fc !== 2'd1) begin n_fail++; $display("FAIL mid_pre1 fc got=%0d exp=1", d1_fc); end
      tick1(1'b1, 1'b0);
      n_run++;
      if (obs1 !== exp1(0)) begin n_fail++; $display("FAIL mid_reset1 got=%h exp=%h", obs1, exp1(0)); end
      for (int i = 0; i < 120; i++) begin
         tick1(1'b0, 1'b1);
         n_run++;
         if (obs1 !== exp1(n1)) begin n_fail++; $display("FAIL mid_run1 i=%0d got=%h exp=%h", i, obs1, exp1(n1)); end
      end
   endtask

   task automatic test_frames_small;
      logic [1:0] seq [7];
      int k, vs_cnt, steps;
      logic en;
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
      k = 0; vs_cnt = 0; steps = 0;
      tick1(1'b1, 1'b0);
      for (int i = 0; i < 3000 && k < 7; i++) begin
         en = logic'($urandom_range(0, 3) != 0);
         tick1(1'b0, en);
         n_run++;
         if (obs1 !== exp1(n1)) begin n_fail++; $display("FAIL frames1 i=%0d got=%h exp=%h", i, obs1, exp1(n1)); end
         if (en && d1_fs) begin
            n_run++;
            if (d1_fc !== seq[k]) begin n_fail++; $display("FAIL fc_seq k=%0d got=%0d exp=%0d", k, d1_fc, seq[k]); end
            k++;
         end
         if (en && k == 1) begin
            steps++;
            if (d1_vs) vs_cnt++;
         end
      end
      n_run++;
      if (k !== 7) begin n_fail++; $display("FAIL frame_starts got=%0d exp=7", k); end
      n_run++;
      if (steps !== 105 || vs_cnt !== 15) begin
         n_fail++;
         $display("FAIL frame1_period steps=%0d vs_edges=%0d exp 105/15", steps, vs_cnt);
      end
   endtask

   task automatic test_frames_low;
      tick2(1'b1, 1'b1);
      for (int i = 0; i < 700; i++) begin
         tick2(1'b0, logic'($urandom_range(0, 1)));
         n_run++;
         if (obs2 !== exp2(n2)) begin n_fail++; $display("FAIL frames2 i=%0d got=%h exp=%h", i, obs2, exp2(n2)); end
      end
   endtask

   initial begin
      rst0 = 1'b1; pen0 = 1'b0;
      rst1 = 1'b1; pen1 = 1'b0;
      rst2 = 1'b1; pen2 = 1'b0;
      test_reset();
      test_line();
      test_pix_en();
      test_reset_mid();
      test_frames_small();
      test_frames_low();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
